serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement/unsigned subtractor computing diff = a - b, one bit per clock, LSB first.
- Core cell is a full subtractor (difference/borrow), the inverse arithmetic of the team's full adder.
- Operand load and result return use a start/busy/done handshake.
- Intended as the area-minimal subtract path beside the ripple adder in the datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 2).

Ports:
- clk    input   1        system clock, rising-edge active
- rst    input   1        synchronous, active-high reset
- start  input   1        request; sampled only when busy=0
- a      input   WIDTH    minuend, captured on accepted start
- b      input   WIDTH    subtrahend, captured on accepted start
- busy   output  1        high while an operation is in progress
- done   output  1        one-cycle pulse when diff/bout become valid
- diff   output  WIDTH    result a - b (mod 2^WIDTH), held until next completion
- bout   output  1        final borrow (1 ⇔ a < b unsigned), held with diff

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset state (edge with rst=1): FSM=IDLE, busy=0, done=0, diff=0, bout=0. Internal shift registers, borrow flop and bit counter are also 0.
- rst has priority over every other input, including mid-operation. It aborts the operation with no done pulse and returns to IDLE on the next edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, capture a→sa, b→sb; clear borrow br=0, counter cnt=0, shift result sr=0.
  - Next state RUN.
- RUN: one bit per edge.
  - d = sa[0]^sb[0]^br
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - sr = {d, sr[WIDTH-1:1]}; sa and sb shift right by 1; cnt++.
  - When cnt reaches WIDTH-1 (the WIDTH-th bit), next state DONE.
  - Alongside that transition, load diff ← final sr and bout ← final br_next.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE: operands captured, next state RUN. This gives back-to-back operation.
  - Otherwise next state IDLE.
- busy=1 in RUN only. busy=0 in IDLE and DONE.
- start while busy=1 is ignored, with no effect on the operation in flight.
- a and b are don't-care except on the accepting edge.
- Latency: start accepted at edge N; done high during the cycle after edge N+WIDTH. With WIDTH=8, done is high in cycle 9 counting the accept edge as 0. Throughput is one result per WIDTH+1 cycles.
- diff and bout change only on the edge entering DONE. They remain stable through IDLE and the following RUN.
- Arithmetic wraps modulo 2^WIDTH. bout = NOT(carry-out of a + ~b + 1).
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h23, start pulse → busy for 8 cycles, done one cycle, diff=8'h37, bout=0; diff still 8'h37 five cycles later.
- a=8'h10, b=8'h20 → diff=8'hF0, bout=1. Then a=8'h00, b=8'hFF → diff=8'h01, bout=1. Then a=8'hFF, b=8'hFF → diff=8'h00, bout=0.
- Start accepted with a=8'h80, b=8'h01; 3 cycles later assert start with a=8'h00, b=8'h01 → ignored; result diff=8'h7F, bout=0, single done pulse.
- Start with a=8'h33, b=8'h11; rst=1 on the 4th RUN cycle → next edge busy=0, done=0, diff=0, bout=0, no done pulse. A new start then yields diff=8'h22 normally.
- Hold start=1 continuously with operands changing each accept (8'h05-8'h03, then 8'h03-8'h05) → done every 9 cycles; diffs 8'h02/bout 0, then 8'hFE/bout 1.
- Exhaustive check at WIDTH=4: all 256 (a,b) pairs vs reference model (a-b) mod 16 and a<b.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b (mod 2^WIDTH), one bit per clock,
//   LSB first. A single full-subtractor cell is reused every cycle.
//   Operands are loaded with a start/busy/done handshake.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset, overrides everything
//   start  in   request, honoured only in IDLE or DONE (busy=0)
//   a, b   in   minuend / subtrahend, sampled on the accepting edge
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse when diff/bout are updated
//   diff   out  a - b, held until the next completion
//   bout   out  final borrow, 1 when a < b unsigned
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             br;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs.
  logic d, br_next;
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Result word after shifting in this cycle's bit; on the last bit this
  // is the complete difference.
  logic [WIDTH-1:0] sr_next;
  assign sr_next = {d, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        // DONE accepts a new start exactly like IDLE so that a held start
        // gives one result every WIDTH+1 cycles.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sr  <= sr_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= sr_next;
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, diff8;
  logic [3:0] a4, b4, diff4;
  logic       busy8, done8, bout8;
  logic       busy4, done4, bout4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));

  // Reference: plain modular arithmetic.
  function automatic logic [7:0] ref_diff8(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[7:0];
  endfunction

  // Wait (at negedges) for done on the 8-bit DUT, starting at the negedge
  // right after the accept edge. lat counts cycles since accept.
  task automatic wait_done8(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (lat < 40) begin
      lat++;
      if (busy8) busy_cnt++;
      if (done8) break;
      @(negedge clk);
    end
    checks++;
    if (done8 !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout8: done=%b after %0d cycles, required 1", done8, lat);
    end
  endtask

  // Full op on dut8: pulse start for one edge, wait for done.
  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(lat, busy_cnt);
  endtask

  task automatic check_res8(input string nm, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] ed; logic eb;
    ed = ref_diff8(x, y);
    eb = (x < y);
    checks++;
    if (diff8 !== ed || bout8 !== eb) begin
      failures++;
      $display("FAIL %s: a=%h b=%h diff=%h bout=%b, required diff=%h bout=%b",
               nm, x, y, diff8, bout8, ed, eb);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; a4 = 4'h0; b4 = 4'h0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'b0) begin
      failures++;
      $display("FAIL reset8: busy=%b done=%b diff=%h bout=%b, required all 0",
               busy8, done8, diff8, bout8);
    end
    checks++;
    if ({busy4, done4, diff4, bout4} !== 7'b0) begin
      failures++;
      $display("FAIL reset4: busy=%b done=%b diff=%h bout=%b, required all 0",
               busy4, done4, diff4, bout4);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    op8(8'h5A, 8'h23, lat, bc);
    check_res8("basic_5A_23", 8'h5A, 8'h23);
    checks++;
    if (lat != 9 || bc != 8) begin
      failures++;
      $display("FAIL basic_latency: done at cycle %0d busy cycles %0d, required 9 and 8", lat, bc);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse: done=%b busy=%b one cycle after done, required 0/0", done8, busy8);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (diff8 !== 8'h37 || bout8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: diff=%h bout=%b, required 37/0", diff8, bout8);
    end
  endtask

  task automatic test_corners;
    int lat, bc;
    op8(8'h10, 8'h20, lat, bc); check_res8("corner_10_20", 8'h10, 8'h20);
    op8(8'h00, 8'hFF, lat, bc); check_res8("corner_00_FF", 8'h00, 8'hFF);
    op8(8'hFF, 8'hFF, lat, bc); check_res8("corner_FF_FF", 8'hFF, 8'hFF);
    op8(8'h00, 8'h00, lat, bc); check_res8("corner_00_00", 8'h00, 8'h00);
    op8(8'h7F, 8'h80, lat, bc); check_res8("corner_7F_80", 8'h7F, 8'h80);
  endtask

  task automatic test_random;
    int lat, bc;
    logic [7:0] x, y;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      op8(x, y, lat, bc);
      check_res8("random", x, y);
    end
  endtask

  task automatic test_ignored_start;
    int lat, bc, pulses;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (lat < 40 && done8 !== 1'b1) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (done8 !== 1'b1 || lat != 9) begin
      failures++;
      $display("FAIL ignored_latency: done=%b at cycle %0d, required 1 at 9", done8, lat);
    end
    check_res8("ignored_result", 8'h80, 8'h01);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL ignored_extra_done: %0d extra done pulses, required 0", pulses);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc, pulses;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(negedge clk);            // RUN cycle 1
    start8 = 1'b0;
    repeat (3) @(negedge clk); // RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy8, done8, diff8, bout8} !== 11'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b diff=%h bout=%b, required all 0",
               busy8, done8, diff8, bout8);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_activity: %0d cycles with busy/done after abort, required 0", pulses);
    end
    op8(8'h33, 8'h11, lat, bc);
    check_res8("abort_restart", 8'h33, 8'h11);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h05;    // operands for the accept in DONE
    wait_done8(lat, bc);
    check_res8("b2b_first", 8'h05, 8'h03);
    checks++;
    if (lat != 9) begin
      failures++;
      $display("FAIL b2b_first_latency: done at cycle %0d, required 9", lat);
    end
    @(negedge clk);
    a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(lat, bc);
    check_res8("b2b_second", 8'h03, 8'h05);
    checks++;
    if (lat != 9 || bc != 8) begin
      failures++;
      $display("FAIL b2b_period: done %0d cycles after previous, busy %0d, required 9 and 8", lat, bc);
    end
    start8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop: busy=%b done=%b, required 0/0", busy8, done8);
    end
  endtask

  task automatic test_exhaustive4;
    int lat, bad;
    logic [3:0] ed; logic eb;
    bad = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        start4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 1;
        while (lat < 20 && done4 !== 1'b1) begin
          @(negedge clk); lat++;
        end
        ed = 4'((x - y + 16) % 16);
        eb = (x < y);
        checks++;
        if (done4 !== 1'b1 || lat != 5 || diff4 !== ed || bout4 !== eb) begin
          failures++;
          bad++;
          if (bad <= 10)
            $display("FAIL exh4: a=%h b=%h done=%b lat=%0d diff=%h bout=%b, required done at 5 diff=%h bout=%b",
                     x[3:0], y[3:0], done4, lat, diff4, bout4, ed, eb);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_random;
    test_ignored_start;
    test_reset_abort;
    test_back_to_back;
    test_exhaustive4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
